uart_rx_framer: RTL and testbench
=================================

// Module: uart_rx_framer
// PURPOSE
//  Serial UART receiver feeding uart_controller's byte interface: resamples the rx pin,
//  detects start bits, recovers 8N1 frames LSB-first and emits each byte with a 1-cycle
//  valid strobe. Also flags framing errors and reports line activity.
//  Sits between the board rx pin and the controller's command/data parser.
// PARAMETERS
//  CLKS_PER_BIT  100  clk_50M cycles per bit (100 = 500 kbps); legal range 8..65535
// PORTS
//  clk_50M       in   1  system clock, all logic on rising edge
//  reset         in   1  synchronous, active-high reset
//  uart_rx_pin   in   1  asynchronous serial input, idle high
//  rx_byte       out  8  last received byte; held stable until the next rx_valid
//  rx_valid      out  1  1-cycle strobe: rx_byte holds a newly received, good frame
//  rx_frame_err  out  1  1-cycle strobe: stop bit sampled low, byte discarded
//  rx_busy       out  1  high from start-bit detection until frame completes/aborts
// BEHAVIOUR
//  - Single clock domain, synchronous active-high reset. Reset values: rx_byte=0,
//    rx_valid=0, rx_frame_err=0, rx_busy=0, state=IDLE, counters=0, sync regs=1.
//  - uart_rx_pin passes a 2-flop synchroniser (rx_s); all decisions use rx_s only.
//  - Bit counter: 16-bit clk counter, bit index 0..7 (3 bits); no width narrower.
//  - States:
//    IDLE: rx_busy=0. rx_s==0 -> START, clk counter=0, rx_busy=1 next cycle.
//    START: count to CLKS_PER_BIT/2-1 (integer division), sample rx_s at that cycle.
//      Sample 0 -> DATA, counter=0, bit index=0. Sample 1 -> IDLE (glitch, no strobe).
//    DATA: sample rx_s when counter reaches CLKS_PER_BIT-1, shift into bit[index]
//      (LSB first), counter=0; after index 7 -> STOP.
//    STOP: sample at CLKS_PER_BIT-1. rx_s==1 -> rx_byte<=shift reg, rx_valid=1 for
//      one cycle, -> IDLE. rx_s==0 -> rx_frame_err=1 one cycle, rx_byte unchanged,
//      -> WAIT_HIGH.
//    WAIT_HIGH: rx_busy=1; stay until rx_s==1, then -> IDLE (break/garbage lockout).
//  - Sampling is mid-bit; return to IDLE at stop-bit centre so a start bit
//    arriving half a bit later is captured (back-to-back frames at full rate).
//  - Latency: pin falling edge at cycle T -> rx_valid at T+2+CLKS_PER_BIT/2+9*CLKS_PER_BIT
//    (+/-1 cycle for synchroniser phase); 952 cycles at default.
//  - rx_valid and rx_frame_err never assert in the same cycle; each is exactly 1 cycle.
//  - No buffering: consumer must take rx_byte within CLKS_PER_BIT*10 cycles
//    (next frame overwrites it); no overrun flag.
//  - Reset mid-frame: abort immediately, no strobe, next cycle in IDLE; a low line
//    after reset release is treated as a fresh start bit.
//  - Pin held constantly low (break): one rx_frame_err, then WAIT_HIGH until release.
// TESTING
//  1. Reset, send 0xA5 8N1 at CLKS_PER_BIT=100 -> rx_valid 1 cycle at ~952 cycles
//     after start edge, rx_byte=0xA5, rx_frame_err never high.
//  2. Back-to-back frames 0x00,0xFF,0x01 with no idle gap -> three rx_valid strobes
//     ~1000 cycles apart, bytes in order.
//  3. 20-cycle low glitch on idle line -> no strobes, rx_busy high ~50 cycles then 0.
//  4. Frame 0x3C with stop bit driven low -> rx_frame_err 1 cycle, rx_byte keeps
//     previous value, rx_busy stays 1 until line returns high.
//  5. Pin held low 5000 cycles -> exactly one rx_frame_err, no rx_valid; then
//     release and send 0x55 -> rx_valid with 0x55.
//  6. Assert reset at bit 4 of a frame -> outputs return to reset values next cycle,
//     no strobe for the aborted frame; following frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_framer_if.sv
// rtl/uart_rx_framer_if.sv - received-byte strobe bundle between the rx framer and its consumer
interface uart_rx_framer_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    output rx_byte,
    output rx_valid,
    output rx_frame_err,
    output rx_busy
  );

  modport slave (
    input rx_byte,
    input rx_valid,
    input rx_frame_err,
    input rx_busy
  );
endinterface

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - 8N1 UART receiver with mid-bit sampling and framing-error lockout
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             uart_rx_pin,
  uart_rx_framer_if.master rx
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic        rx_meta;
  logic        rx_s;
  logic [2:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_pin;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      rx.rx_byte      <= '0;
      rx.rx_valid     <= 1'b0;
      rx.rx_frame_err <= 1'b0;
      rx.rx_busy      <= 1'b0;
    end else begin
      rx.rx_valid     <= 1'b0;
      rx.rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state      <= START;
            rx.rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Start bit gone by its centre: treat as line noise.
              state      <= IDLE;
              rx.rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            // Leave at the stop-bit centre so a start bit half a bit later is caught.
            if (rx_s) begin
              rx.rx_byte  <= shift;
              rx.rx_valid <= 1'b1;
              rx.rx_busy  <= 1'b0;
              state       <= IDLE;
            end else begin
              rx.rx_frame_err <= 1'b1;
              state           <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state      <= IDLE;
            rx.rx_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          rx.rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - scoreboard bench for uart_rx_framer at CLKS_PER_BIT=100
module tb_uart_rx_framer;
  localparam int CPB = 100;

  logic clk_50M = 1'b0;
  logic reset   = 1'b1;
  logic uart_rx_pin = 1'b1;

  uart_rx_framer_if rx ();

  uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .uart_rx_pin (uart_rx_pin),
    .rx          (rx.master)
  );

  always #10 clk_50M = ~clk_50M;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_count = 0;
  int ferr_count = 0;
  int wide_valid = 0;
  int wide_ferr = 0;
  int both_high = 0;
  int last_start_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];

  always @(posedge clk_50M) cyc <= cyc + 1;

  always @(negedge clk_50M) begin
    if (rx.rx_valid) begin
      obs_q.push_back(rx.rx_byte);
      obs_cyc_q.push_back(cyc);
      valid_count++;
      if (prev_valid) wide_valid++;
    end
    if (rx.rx_frame_err) begin
      ferr_count++;
      if (prev_ferr) wide_ferr++;
    end
    if (rx.rx_valid && rx.rx_frame_err) both_high++;
    prev_valid = rx.rx_valid;
    prev_ferr  = rx.rx_frame_err;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk_50M);
    last_start_cyc = cyc;
    uart_rx_pin = 1'b0;
    repeat (CPB - 1) @(negedge clk_50M);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_50M);
      uart_rx_pin = b[i];
      repeat (CPB - 1) @(negedge clk_50M);
    end
    @(negedge clk_50M);
    uart_rx_pin = stop_bit;
    repeat (CPB - 1) @(negedge clk_50M);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk_50M);
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk_50M);
    checks++;
    if (rx.rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", rx.rx_byte); end
    checks++;
    if (rx.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx.rx_valid); end
    checks++;
    if (rx.rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", rx.rx_frame_err); end
    checks++;
    if (rx.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx.rx_busy); end
    reset = 1'b0;
    repeat (20) @(negedge clk_50M);
  endtask

  task automatic test_single;
    bit ok;
    logic [7:0] e, o;
    int t, lat;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    t = last_start_cyc;
    wait_obs(1, 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_timeout got %0d strobes want 1", obs_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); lat = obs_cyc_q.pop_front() - t;
      checks++;
      if (o !== e) begin errors++; $display("FAIL single_byte got %h want %h", o, e); end
      checks++;
      if (lat < 951 || lat > 954) begin errors++; $display("FAIL single_latency got %0d want 951..954", lat); end
    end
    repeat (100) @(negedge clk_50M);
    checks++;
    if (ferr_count !== 0) begin errors++; $display("FAIL single_ferr got %0d want 0", ferr_count); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [7:0] e, o;
    int c[3];
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    wait_obs(3, 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_timeout got %0d strobes want 3", obs_q.size());
      obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); c[i] = obs_cyc_q.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, o, e); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (c[i] - c[i-1] < 999 || c[i] - c[i-1] > 1001)
          begin errors++; $display("FAIL b2b_gap%0d got %0d want 1000", i, c[i] - c[i-1]); end
      end
    end
    repeat (200) @(negedge clk_50M);
  endtask

  task automatic test_glitch;
    int busy_cycles = 0;
    int v0 = valid_count;
    int f0 = ferr_count;
    @(negedge clk_50M);
    uart_rx_pin = 1'b0;
    for (int i = 0; i < 220; i++) begin
      if (i == 20) uart_rx_pin = 1'b1;
      @(negedge clk_50M);
      if (rx.rx_busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles < 48 || busy_cycles > 52) begin errors++; $display("FAIL glitch_busy_len got %0d want 50", busy_cycles); end
    checks++;
    if (valid_count != v0 || ferr_count != f0)
      begin errors++; $display("FAIL glitch_strobes got v%0d f%0d want v%0d f%0d", valid_count, ferr_count, v0, f0); end
    checks++;
    if (rx.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b want 0", rx.rx_busy); end
  endtask

  task automatic test_frame_err;
    int v0 = valid_count;
    int f0 = ferr_count;
    send_byte(8'h3C, 1'b0);
    repeat (300) @(negedge clk_50M);
    checks++;
    if (ferr_count != f0 + 1) begin errors++; $display("FAIL ferr_count got %0d want %0d", ferr_count - f0, 1); end
    checks++;
    if (valid_count != v0) begin errors++; $display("FAIL ferr_no_valid got %0d want 0", valid_count - v0); end
    checks++;
    if (rx.rx_byte !== 8'h01) begin errors++; $display("FAIL ferr_byte_held got %h want 01", rx.rx_byte); end
    checks++;
    if (rx.rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low_line got %b want 1", rx.rx_busy); end
    uart_rx_pin = 1'b1;
    repeat (6) @(negedge clk_50M);
    checks++;
    if (rx.rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b want 0", rx.rx_busy); end
    repeat (100) @(negedge clk_50M);
  endtask

  task automatic test_break;
    bit ok;
    logic [7:0] e, o;
    int v0 = valid_count;
    int f0 = ferr_count;
    @(negedge clk_50M);
    uart_rx_pin = 1'b0;
    repeat (5000) @(negedge clk_50M);
    checks++;
    if (ferr_count != f0 + 1) begin errors++; $display("FAIL break_ferr got %0d want 1", ferr_count - f0); end
    checks++;
    if (valid_count != v0) begin errors++; $display("FAIL break_valid got %0d want 0", valid_count - v0); end
    uart_rx_pin = 1'b1;
    repeat (100) @(negedge clk_50M);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    wait_obs(1, 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL break_rx_timeout got %0d strobes want 1", obs_q.size());
      exp_q.delete();
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
      checks++;
      if (o !== e) begin errors++; $display("FAIL break_rx_byte got %h want %h", o, e); end
    end
    repeat (100) @(negedge clk_50M);
  endtask

  task automatic test_reset_midframe;
    bit ok;
    logic [7:0] e, o;
    int v0, f0;
    @(negedge clk_50M);
    uart_rx_pin = 1'b0;
    repeat (5 * CPB) @(negedge clk_50M);
    uart_rx_pin = 1'b1;
    repeat (CPB / 2) @(negedge clk_50M);
    checks++;
    if (rx.rx_busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b want 1", rx.rx_busy); end
    reset = 1'b1;
    @(negedge clk_50M);
    checks++;
    if (rx.rx_busy !== 1'b0 || rx.rx_valid !== 1'b0 || rx.rx_frame_err !== 1'b0 || rx.rx_byte !== 8'h00)
      begin errors++; $display("FAIL midframe_reset got b%b v%b f%b %h want b0 v0 f0 00",
                               rx.rx_busy, rx.rx_valid, rx.rx_frame_err, rx.rx_byte); end
    reset = 1'b0;
    v0 = valid_count; f0 = ferr_count;
    repeat (1200) @(negedge clk_50M);
    checks++;
    if (valid_count != v0 || ferr_count != f0)
      begin errors++; $display("FAIL midframe_no_strobe got v%0d f%0d want 0 0", valid_count - v0, ferr_count - f0); end
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    wait_obs(1, 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL after_reset_timeout got %0d strobes want 1", obs_q.size());
      exp_q.delete();
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
      checks++;
      if (o !== e) begin errors++; $display("FAIL after_reset_byte got %h want %h", o, e); end
    end
    repeat (100) @(negedge clk_50M);
  endtask

  task automatic test_strobe_shape;
    checks++;
    if (wide_valid != 0) begin errors++; $display("FAIL valid_width got %0d long pulses want 0", wide_valid); end
    checks++;
    if (wide_ferr != 0) begin errors++; $display("FAIL ferr_width got %0d long pulses want 0", wide_ferr); end
    checks++;
    if (both_high != 0) begin errors++; $display("FAIL valid_and_ferr got %0d cycles want 0", both_high); end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL unexpected_bytes got %0d want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_midframe();
    test_strobe_shape();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
